spike_volley_encoder: RTL and testbench

- Upstream feeder for the clocked-STDP layer: accepts a stream of pixel intensities and converts each to a temporal spike time (brighter pixel spikes earlier).
- Double-buffers one volley so the next image loads while the current one runs.
- Drives the layer's time_val sweep, packed spike_times and per-volley training flag.

---
 rtl/spike_volley_encoder.sv | 154 +++++++++++++++
 tb/tb_spike_volley_encoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_volley_encoder.sv
// rtl/spike_volley_encoder.sv - pixel-to-spike-time encoder with double-buffered volleys; optional volley counter under SPIKE_VOLLEY_ENCODER_COUNT_EN
module spike_volley_encoder #(
  parameter int NUM_INPUTS = 16,
  parameter int PIX_W      = 8,
  parameter int LOG_TP     = 3,
  parameter int TIME_W     = 6,
  parameter int MIN_PIX    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pix_valid,
  output logic                             pix_ready,
  input  logic [PIX_W-1:0]                 pix_data,
  input  logic                             pix_train,
  output logic [TIME_W-1:0]                time_val,
  output logic [NUM_INPUTS*(LOG_TP+1)-1:0] spike_times,
  output logic                             training,
  output logic                             volley_start,
  output logic                             volley_done,
  output logic [15:0]                      volley_count
);

  localparam int ENC_W          = LOG_TP + 1;
  localparam int TESTING_PERIOD = 1 << LOG_TP;
  localparam int TIME_PERIOD    = TESTING_PERIOD + NUM_INPUTS;
  localparam int CNT_W          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  localparam logic [ENC_W-1:0]  NO_SPIKE   = '1;
  localparam logic [TIME_W-1:0] T_END      = TIME_W'(TIME_PERIOD - 1);
  localparam logic [TIME_W-1:0] T_TEST_END = TIME_W'(TESTING_PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(NUM_INPUTS - 1);
  localparam logic [PIX_W-1:0]  PIX_MIN    = PIX_W'(MIN_PIX);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [ENC_W-1:0]  fill_buf [NUM_INPUTS];
  logic [ENC_W-1:0]  act_buf  [NUM_INPUTS];
  logic [CNT_W-1:0]  fill_cnt;
  logic              fill_full;
  logic              fill_train;
  logic              accept;
  logic              at_last;
  logic              swap;
  logic              finish;
  logic [TIME_W-1:0] last_time;
  logic [ENC_W-1:0]  pix_enc;

  // Fill side stalls only while a complete volley waits for its swap
  assign pix_ready    = !fill_full;
  assign accept       = pix_valid && pix_ready;
  assign last_time    = training ? T_END : T_TEST_END;
  assign at_last      = (time_val == last_time);
  assign volley_start = (state == RUN) && (time_val == '0);
  assign volley_done  = (state == RUN) && at_last;

  // Brighter pixel -> earlier spike: invert the top LOG_TP bits; dim pixels never spike
  always_comb begin
    pix_enc = NO_SPIKE;
    if (pix_data >= PIX_MIN) pix_enc = {1'b0, ~pix_data[PIX_W-1 -: LOG_TP]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus swap/finish decisions
  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (fill_full) begin
          swap      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (at_last) begin
          if (fill_full) begin
            swap = 1'b1;
          end else begin
            finish    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fill buffer load, active buffer swap and time sweep
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt   <= '0;
      fill_full  <= 1'b0;
      fill_train <= 1'b0;
      training   <= 1'b0;
      time_val   <= T_END;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        fill_buf[i] <= NO_SPIKE;
        act_buf[i]  <= NO_SPIKE;
      end
    end else begin
      if (accept) begin
        fill_buf[fill_cnt] <= pix_enc;
        if (fill_cnt == CNT_LAST) begin
          fill_full  <= 1'b1;
          fill_cnt   <= '0;
          fill_train <= pix_train;
        end else begin
          fill_cnt <= fill_cnt + 1'b1;
        end
      end
      // swap needs fill_full, accept needs !fill_full, so they never collide on fill_full
      if (swap) begin
        for (int i = 0; i < NUM_INPUTS; i++) act_buf[i] <= fill_buf[i];
        training  <= fill_train;
        fill_full <= 1'b0;
        time_val  <= '0;
      end else if (finish) begin
        for (int i = 0; i < NUM_INPUTS; i++) act_buf[i] <= NO_SPIKE;
        training <= 1'b0;
        time_val <= T_END;
      end else if (state == RUN) begin
        time_val <= time_val + 1'b1;
      end
    end
  end

  // Pack the active buffer onto the layer bus, entry i at the low end for i = 0
  always_comb begin
    spike_times = '0;
    for (int i = 0; i < NUM_INPUTS; i++) spike_times[i*ENC_W +: ENC_W] = act_buf[i];
  end

`ifdef SPIKE_VOLLEY_ENCODER_COUNT_EN
  logic [15:0] vcnt;

  // Completed-volley counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst)              vcnt <= '0;
    else if (volley_done) vcnt <= vcnt + 16'd1;
  end

  assign volley_count = vcnt;
`else
  assign volley_count = 16'd0;
`endif

endmodule

// File: tb/tb_spike_volley_encoder.sv
// tb/tb_spike_volley_encoder.sv - scoreboard bench for spike_volley_encoder
module tb_spike_volley_encoder;

  localparam int N    = 16;
  localparam int ST_W = N * 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            pix_valid;
  logic            pix_ready;
  logic [7:0]      pix_data;
  logic            pix_train;
  logic [5:0]      time_val;
  logic [ST_W-1:0] spike_times;
  logic            training;
  logic            volley_start;
  logic            volley_done;
  logic [15:0]     volley_count;

  spike_volley_encoder dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_train(pix_train), .time_val(time_val),
    .spike_times(spike_times), .training(training), .volley_start(volley_start),
    .volley_done(volley_done), .volley_count(volley_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ST_W-1:0] st;
    logic            train;
    int              ready;
  } vol_t;

  vol_t        exp_q[$];
  vol_t        cur;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  bit          in_volley = 1'b0;
  bit          exp_start_next = 1'b0;
  bit          prev_done = 1'b0;
  int          t = 0;
  int          last_t = 0;
  int          b2b = 0;
  logic [15:0] done_cnt = 16'd0;
  logic [7:0]  stim_px [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [ST_W-1:0] act, input logic [ST_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference encoding: pixels below 16 never spike, otherwise time = 7 - pixel/32
  function automatic logic [3:0] enc(input logic [7:0] p);
    int tm;
    if (p < 16) return 4'hF;
    tm = 7 - (int'(p) / 32);
    return {1'b0, 3'(tm)};
  endfunction

  function automatic logic [ST_W-1:0] pack_exp();
    logic [ST_W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s[i*4 +: 4] = enc(stim_px[i]);
    return s;
  endfunction

  // Monitor: tracks expected volley timing and compares every output each cycle
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_done;
      bit head_ready;
      chk("volley_start", {63'd0, volley_start}, {63'd0, exp_start_next});
      if (volley_start) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_volley", 64'd1, 64'd0);
        end else begin
          cur       = exp_q.pop_front();
          in_volley = 1'b1;
          t         = 0;
          last_t    = cur.train ? 23 : 7;
          if (prev_done) b2b++;
        end
      end else if (in_volley) begin
        t++;
      end
      if (in_volley) begin
        chk("run_time_val", {58'd0, time_val}, 64'(t));
        chk("run_spike_times", spike_times, cur.st);
        chk("run_training", {63'd0, training}, {63'd0, cur.train});
      end else begin
        chk("idle_time_val", {58'd0, time_val}, 64'd23);
        chk("idle_spike_times", spike_times, '1);
        chk("idle_training", {63'd0, training}, 64'd0);
      end
      exp_done = in_volley && (t == last_t);
      chk("volley_done", {63'd0, volley_done}, {63'd0, exp_done});
      if (exp_done) begin
        in_volley = 1'b0;
        done_cnt  = done_cnt + 16'd1;
      end
      prev_done  = exp_done;
      head_ready = (exp_q.size() > 0) && (exp_q[0].ready <= cyc);
      chk("pix_ready", {63'd0, pix_ready}, {63'd0, !head_ready});
      exp_start_next = head_ready && !in_volley;
    end
  end

  // Drive n beats from stim_px; the final beat of a full volley pushes the expectation
  task automatic send_beats(input int n, input bit push, input int max_gap, input bit train);
    int waitc;
    vol_t v;
    for (int i = 0; i < n; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      pix_valid = 1'b0;
      repeat (g) @(negedge clk);
      pix_valid = 1'b1;
      pix_data  = stim_px[i];
      pix_train = (i == N - 1) ? train : 1'($urandom_range(0, 1));
      waitc = 0;
      while (!pix_ready) begin
        @(negedge clk);
        waitc++;
        if (waitc > 1000) begin
          chk("pix_ready_timeout", 64'd0, 64'd1);
          pix_valid = 1'b0;
          return;
        end
      end
      if (push && i == N - 1) begin
        v.st    = pack_exp();
        v.train = train;
        v.ready = cyc + 1;
        exp_q.push_back(v);
      end
      @(negedge clk);
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (exp_q.size() != 0 || in_volley || exp_start_next) begin
      @(negedge clk);
      c++;
      if (c > 2000) begin
        chk("idle_timeout", 64'd0, 64'd1);
        return;
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_count();
`ifdef SPIKE_VOLLEY_ENCODER_COUNT_EN
    chk("volley_count", {48'd0, volley_count}, {48'd0, done_cnt});
`else
    chk("volley_count", {48'd0, volley_count}, 64'd0);
`endif
  endtask

  task automatic chk_reset_state();
    chk("rst_time_val", {58'd0, time_val}, 64'd23);
    chk("rst_spike_times", spike_times, '1);
    chk("rst_training", {63'd0, training}, 64'd0);
    chk("rst_volley_start", {63'd0, volley_start}, 64'd0);
    chk("rst_volley_done", {63'd0, volley_done}, 64'd0);
    chk("rst_pix_ready", {63'd0, pix_ready}, 64'd1);
    chk("rst_volley_count", {48'd0, volley_count}, 64'd0);
  endtask

  task automatic rand_px(input int lo_bias);
    for (int i = 0; i < N; i++)
      stim_px[i] = (lo_bias != 0 && $urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    rst = 1'b1; pix_valid = 1'b1; pix_data = 8'd0; pix_train = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; pix_valid = 1'b0;
    chk_reset_state();
    mon_en = 1'b1;
    @(negedge clk);

    // All-bright training-off volley
    for (int i = 0; i < N; i++) stim_px[i] = 8'd255;
    send_beats(N, 1'b1, 2, 1'b0);
    wait_idle();

    // Boundary pattern with training on
    for (int i = 0; i < N; i++) begin
      logic [7:0] pat [4];
      pat[0] = 8'd255; pat[1] = 8'd128; pat[2] = 8'd32; pat[3] = 8'd15;
      stim_px[i] = pat[i % 4];
    end
    send_beats(N, 1'b1, 1, 1'b1);
    wait_idle();

    rand_px(1);
    send_beats(N, 1'b1, 3, 1'b0);
    wait_idle();
    chk("three_volleys_done", {48'd0, done_cnt}, 64'd3);
    chk_count();

    // Streamed volleys with no valid gaps: training volley then two short ones
    rand_px(1); send_beats(N, 1'b1, 0, 1'b1);
    rand_px(1); send_beats(N, 1'b1, 0, 1'b0);
    rand_px(1); send_beats(N, 1'b1, 0, 1'b0);
    wait_idle();
    chk("back_to_back_seen", 64'(b2b > 0), 64'd1);

    // Random volleys with random gaps and training flags
    for (int k = 0; k < 6; k++) begin
      rand_px(1);
      send_beats(N, 1'b1, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    chk_count();

    // Reset mid-volley with a partially filled next volley
    rand_px(0);
    send_beats(N, 1'b1, 0, 1'b1);
    rand_px(0);
    send_beats(3, 1'b0, 0, 1'b0);
    c = 0;
    while (time_val != 6'd5 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("reach_time_5", {58'd0, time_val}, 64'd5);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_state();
    exp_q.delete();
    in_volley = 1'b0; exp_start_next = 1'b0; prev_done = 1'b0;
    done_cnt = 16'd0;
    mon_en = 1'b1;
    @(negedge clk);

    rand_px(1);
    send_beats(N, 1'b1, 1, 1'b0);
    wait_idle();
    chk_count();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
